imem_fetch_port: RTL and testbench

Parametrised, clocked instruction memory for the RISC-V core, replacing the combinational byte-array ROM. Words are stored little-endian and word-addressed internally. A side-band programming port loads the program, and a valid/ready fetch port returns a registered instruction with fault flags. After every reset, a clear sequencer fills the whole array with NOP before any access is accepted.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_word_ram.sv | 36 +++
 rtl/imem_fetch_port.sv | 124 ++++++++++++
 tb/tb_imem_fetch_port.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the clocked instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  // Bit 0 is misaligned, bit 1 is out-of-range.
  typedef struct packed {
    logic out_of_range;
    logic misaligned;
  } imem_fault_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_word_ram.sv
// Word-organised RAM: one byte-enabled write port, one registered read port.
module imem_word_ram
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 16,
  parameter int          IDX_W       = 4,
  parameter logic [31:0] RST_WORD    = NOP_WORD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // The read register holds its value between reads so a stalled response stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= RST_WORD;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with a clear sequencer, a side-band program port and a valid/ready fetch port.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 64,
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_fault,
  input  logic              prog_we,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [3:0]        prog_be,
  output logic              init_done,
  output logic              fsm_state
);

  localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W       = $clog2(DEPTH_WORDS);
  localparam int BYTE_W      = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LIMIT     = ADDR_W'(DEPTH_BYTES);
  localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(DEPTH_WORDS - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and a raised rsp_valid holds its data until rsp_ready.

  imem_state_t      state, state_next;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_next;
  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_waddr;
  logic [31:0]      ram_wdata, ram_rdata;
  logic [3:0]       ram_be;
  logic             prog_oor, accept;
  imem_fault_t      fetch_fault, rsp_fault_q;
  logic             unused_prog_lsbs;

  assign unused_prog_lsbs = ^prog_addr[1:0];

  assign prog_oor                 = (prog_addr >= LIMIT);
  assign fetch_fault.misaligned   = (fetch_addr[1:0] != 2'b00);
  assign fetch_fault.out_of_range = (fetch_addr >= LIMIT);

  assign init_done   = (state == RUN);
  assign prog_ready  = init_done;
  assign fsm_state   = state;
  assign fetch_ready = init_done && !prog_we && (!rsp_valid || rsp_ready);
  assign accept      = fetch_valid && fetch_ready;
  assign ram_re      = accept && (fetch_fault == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    ram_we       = 1'b0;
    ram_waddr    = prog_addr[BYTE_W-1:2];
    ram_wdata    = prog_data;
    ram_be       = prog_be;
    case (state)
      CLEAR: begin
        ram_we       = 1'b1;
        ram_waddr    = clr_cnt;
        ram_wdata    = NOP_WORD;
        ram_be       = 4'hF;
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == LAST_WORD) state_next = RUN;
      end
      RUN: begin
        ram_we = prog_we && !prog_oor;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_fault_q <= '0;
    end else if (accept) begin
      rsp_valid   <= 1'b1;
      rsp_fault_q <= fetch_fault;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

  // A faulted response never reads the RAM; the NOP is substituted here instead.
  assign rsp_instr = (rsp_fault_q != '0) ? NOP_WORD : ram_rdata;
  assign rsp_fault = rsp_fault_q;

  imem_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W),
    .RST_WORD   (NOP_WORD)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .be   (ram_be),
    .re   (ram_re),
    .raddr(fetch_addr[BYTE_W-1:2]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: clear, program, fetch, faults, backpressure, reset.
module tb_imem_fetch_port;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;
  logic        prog_we, prog_ready;
  logic [31:0] prog_addr, prog_data;
  logic [3:0]  prog_be;
  logic        init_done, fsm_state;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic [33:0] exp_q[$];
  int          pop_cycle[$];
  logic [33:0] mon_e;

  imem_fetch_port #(.DEPTH_BYTES(64), .ADDR_W(32), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_addr (fetch_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_fault  (rsp_fault),
    .prog_we    (prog_we),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_be    (prog_be),
    .init_done  (init_done),
    .fsm_state  (fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare every response that is consumed
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", {30'd0, rsp_fault, rsp_instr}, {30'd0, mon_e});
        pop_cycle.push_back(cycle);
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef,
                       input bit push, output int waited);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    waited      = 0;
    @(negedge clk);
    while (!fetch_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!fetch_ready) check("fetch_timeout", 64'd0, 64'd1);
    else if (push) exp_q.push_back({ef, ei});
    @(posedge clk); #1;
  endtask

  task automatic fetch_idle();
    fetch_valid = 1'b0;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    prog_be   = be;
    @(negedge clk);
    check("prog_ready", 64'(prog_ready), 64'd1);
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic wait_init(output int edges);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (init_done) break;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int w, e, n0;

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_addr = '0; rsp_ready = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_be = '0;
    #12;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_instr", 64'(rsp_instr), 64'(NOP));
    check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    check("rst_prog_ready", 64'(prog_ready), 64'd0);

    // Clear sequence
    wait_init(e);
    check("clear_edges", 64'(e), 64'd16);
    check("state_run", 64'(fsm_state), 64'd1);
    fetch(32'h00, NOP, 2'b00, 1'b1, w);
    fetch(32'h1C, NOP, 2'b00, 1'b1, w);
    fetch(32'h3C, NOP, 2'b00, 1'b1, w);
    fetch_idle();
    idle_cycles(2);

    // Load and back-to-back fetch
    prog(32'h00, 32'h0000_0033, 4'hF);
    prog(32'h04, 32'h4000_0033, 4'hF);
    prog(32'h08, 32'h0000_6033, 4'hF);
    n0 = pop_cycle.size();
    fetch(32'h00, 32'h0000_0033, 2'b00, 1'b1, w);
    fetch(32'h04, 32'h4000_0033, 2'b00, 1'b1, w);
    fetch(32'h08, 32'h0000_6033, 2'b00, 1'b1, w);
    fetch_idle();
    idle_cycles(2);
    check("b2b_count", 64'(pop_cycle.size() - n0), 64'd3);
    if (pop_cycle.size() == n0 + 3) begin
      check("b2b_gap1", 64'(pop_cycle[n0+1] - pop_cycle[n0]), 64'd1);
      check("b2b_gap2", 64'(pop_cycle[n0+2] - pop_cycle[n0+1]), 64'd1);
    end

    // Byte enables and write-over-fetch priority
    prog_we = 1'b1; prog_addr = 32'h10; prog_data = 32'hAABB_CCDD; prog_be = 4'b0101;
    fetch_valid = 1'b1; fetch_addr = 32'h10;
    @(negedge clk);
    check("prio_fetch_ready", 64'(fetch_ready), 64'd0);
    @(posedge clk); #1;
    prog_we = 1'b0;
    fetch(32'h10, 32'h00BB_00DD, 2'b00, 1'b1, w);
    check("prio_next_accept_wait", 64'(w), 64'd0);
    fetch_idle();
    prog(32'h50, 32'hFFFF_FFFF, 4'hF);
    fetch(32'h10, 32'h00BB_00DD, 2'b00, 1'b1, w);

    // Faults
    fetch(32'h02, NOP, 2'b01, 1'b1, w);
    fetch(32'h40, NOP, 2'b10, 1'b1, w);
    fetch(32'h41, NOP, 2'b11, 1'b1, w);
    fetch(32'hFFFF_FFFC, NOP, 2'b10, 1'b1, w);
    fetch_idle();
    idle_cycles(2);

    // Backpressure
    rsp_ready = 1'b0;
    fetch(32'h04, 32'h4000_0033, 2'b00, 1'b1, w);
    fetch_addr = 32'h08;
    repeat (3) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_instr", 64'(rsp_instr), 64'h4000_0033);
      check("bp_fetch_ready", 64'(fetch_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    fetch(32'h08, 32'h0000_6033, 2'b00, 1'b1, w);
    check("bp_release_wait", 64'(w), 64'd0);
    fetch_idle();
    idle_cycles(2);

    // Reset mid-run
    rsp_ready = 1'b0;
    fetch(32'h00, 32'h0000_0033, 2'b00, 1'b0, w);
    fetch_idle();
    check("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    check("pre_rst_rsp_instr", 64'(rsp_instr), 64'h0000_0033);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_instr", 64'(rsp_instr), 64'(NOP));
    check("mid_rst_init_done", 64'(init_done), 64'd0);
    check("mid_rst_fetch_ready", 64'(fetch_ready), 64'd0);
    wait_init(e);
    check("reclear_edges", 64'(e), 64'd16);
    rsp_ready = 1'b1;
    fetch(32'h00, NOP, 2'b00, 1'b1, w);
    fetch_idle();
    idle_cycles(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
